// File: rtl/operand_entry.sv
// Keypad operand builder: appends decimal digits on a commit key, drops the last digit on
// backspace, and exposes the binary operand plus a 6-digit display window.
module operand_entry #(
    parameter logic [1:0]  ENTRY_STAGE = 2'd0,
    parameter int unsigned MAX_DIG     = 12
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [1:0]  stage,
    input  logic        skey0,
    input  logic        skey1,
    input  logic [3:0]  sw_digit,
    output logic [39:0] value,
    output logic [3:0]  ndig,
    output logic [19:0] disp,
    output logic        err,
    output logic        active
);

    localparam logic [3:0] NDIG_MAX = 4'(MAX_DIG);

    typedef enum logic {StIdle, StEntry} state_e;

    state_e      r_state, w_state_d;
    logic [39:0] r_value, w_value_d;
    logic [3:0]  r_ndig,  w_ndig_d;
    logic        r_err,   w_err_d;
    logic [1:0]  r_arm,   w_arm_d;
    logic [39:0] w_times10;
    logic        w_p0, w_p1;

    assign w_times10 = (r_value << 3) + (r_value << 1);

    always_comb begin
        w_state_d = r_state;
        w_value_d = r_value;
        w_ndig_d  = r_ndig;
        w_err_d   = r_err;
        w_arm_d   = r_arm;
        w_p0      = 1'b0;
        w_p1      = 1'b0;
        case (r_state)
            StIdle: begin
                if (stage == ENTRY_STAGE) begin
                    w_state_d = StEntry;
                    w_value_d = '0;
                    w_ndig_d  = '0;
                    w_err_d   = 1'b0;
                    w_arm_d   = '0;
                end
            end
            StEntry: begin
                if (stage != ENTRY_STAGE) begin
                    w_state_d = StIdle;
                end else begin
                    w_p0    = r_arm[0] & ~skey0;
                    w_p1    = r_arm[1] & ~skey1;
                    // Arm tracks the released level, so a held key disarms after one press.
                    w_arm_d = {skey1, skey0};
                    if (w_p0 && w_p1) begin
                        w_err_d = 1'b1;
                    end else if (w_p0) begin
                        if (sw_digit > 4'd9 || r_ndig == NDIG_MAX) begin
                            w_err_d = 1'b1;
                        end else if (r_value == '0 && sw_digit == 4'd0) begin
                            w_err_d = 1'b0;
                        end else begin
                            w_value_d = w_times10 + {36'd0, sw_digit};
                            w_ndig_d  = r_ndig + 4'd1;
                            w_err_d   = 1'b0;
                        end
                    end else if (w_p1) begin
                        if (r_ndig != 4'd0) begin
                            w_value_d = r_value / 40'd10;
                            w_ndig_d  = r_ndig - 4'd1;
                        end
                        w_err_d = 1'b0;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_value <= '0;
            r_ndig  <= '0;
            r_err   <= 1'b0;
            r_arm   <= '0;
        end else begin
            r_state <= w_state_d;
            r_value <= w_value_d;
            r_ndig  <= w_ndig_d;
            r_err   <= w_err_d;
            r_arm   <= w_arm_d;
        end
    end

    assign value  = r_value;
    assign ndig   = r_ndig;
    assign err    = r_err;
    assign active = (r_state == StEntry);
    assign disp   = 20'(r_value % 40'd1000000);

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: vector table, directed corner sequences, then random keying
// checked against a digit-list reference model.
module tb_operand_entry;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [1:0]  stage;
    logic        skey0, skey1;
    logic [3:0]  sw_digit;
    logic [39:0] value;
    logic [3:0]  ndig;
    logic [19:0] disp;
    logic        err, active;

    operand_entry dut (
        .CLK(CLK), .rst_n(rst_n), .stage(stage), .skey0(skey0), .skey1(skey1),
        .sw_digit(sw_digit), .value(value), .ndig(ndig), .disp(disp), .err(err),
        .active(active)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: the operand is the list of significant digits, MSD first.
    bit m_entry, m_arm0, m_arm1, m_err;
    int m_dig[$];

    typedef struct {
        logic [1:0] st;
        logic       k0;
        logic       k1;
        logic [3:0] d;
        longint     val;
        int         nd;
        logic       e;
        logic       act;
    } vec_t;
    vec_t vt[$];

    function automatic longint m_value();
        longint v = 0;
        foreach (m_dig[i]) v = v * 10 + m_dig[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_entry = 0; m_arm0 = 0; m_arm1 = 0; m_err = 0;
        m_dig.delete();
    endtask

    task automatic model_step(input logic [1:0] st, input logic k0, input logic k1,
                              input logic [3:0] d);
        bit p0, p1;
        if (!m_entry) begin
            if (st == 2'd0) begin
                m_entry = 1; m_err = 0; m_arm0 = 0; m_arm1 = 0;
                m_dig.delete();
            end
        end else if (st != 2'd0) begin
            m_entry = 0;
        end else begin
            p0 = m_arm0 && !k0;
            p1 = m_arm1 && !k1;
            if (k0) m_arm0 = 1; else if (p0) m_arm0 = 0;
            if (k1) m_arm1 = 1; else if (p1) m_arm1 = 0;
            if (p0 && p1) begin
                m_err = 1;
            end else if (p0) begin
                if (d > 9 || m_dig.size() == 12) m_err = 1;
                else if (m_dig.size() == 0 && d == 0) m_err = 0;
                else begin
                    m_dig.push_back(int'(d));
                    m_err = 0;
                end
            end else if (p1) begin
                if (m_dig.size() != 0) m_dig.delete(m_dig.size() - 1);
                m_err = 0;
            end
        end
    endtask

    task automatic cmp_model();
        check("model value", value, m_value());
        check("model ndig", ndig, m_dig.size());
        check("model disp", disp, m_value() % 1000000);
        check("model err", err, m_err);
        check("model active", active, m_entry);
    endtask

    task automatic step(input logic [1:0] st, input logic k0, input logic k1,
                        input logic [3:0] d);
        @(negedge CLK);
        stage = st; skey0 = k0; skey1 = k1; sw_digit = d;
        @(posedge CLK);
        model_step(st, k0, k1, d);
        #1;
        cmp_model();
    endtask

    task automatic commit(input logic [3:0] d);
        step(2'd0, 1'b1, 1'b1, d);
        step(2'd0, 1'b0, 1'b1, d);
        step(2'd0, 1'b1, 1'b1, d);
    endtask

    task automatic backsp();
        step(2'd0, 1'b1, 1'b1, 4'd0);
        step(2'd0, 1'b1, 1'b0, 4'd0);
        step(2'd0, 1'b1, 1'b1, 4'd0);
    endtask

    task automatic add(input logic [1:0] st, input logic k0, input logic k1, input logic [3:0] d,
                       input longint val, input int nd, input logic e, input logic act);
        vec_t v;
        v.st = st; v.k0 = k0; v.k1 = k1; v.d = d; v.val = val; v.nd = nd; v.e = e; v.act = act;
        vt.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; stage = 2'd1; skey0 = 1'b1; skey1 = 1'b1; sw_digit = 4'd0;
        model_reset();
        #3;
        check("reset value", value, 0);
        check("reset ndig", ndig, 0);
        check("reset disp", disp, 0);
        check("reset err", err, 0);
        check("reset active", active, 0);
        @(negedge CLK);
        rst_n = 1'b1;

        add(0, 1, 1, 0,    0, 0, 0, 1);
        add(0, 1, 1, 1,    0, 0, 0, 1);
        add(0, 0, 1, 1,    1, 1, 0, 1);
        add(0, 1, 1, 2,    1, 1, 0, 1);
        add(0, 0, 1, 2,   12, 2, 0, 1);
        add(0, 1, 1, 3,   12, 2, 0, 1);
        add(0, 0, 1, 3,  123, 3, 0, 1);
        add(0, 0, 1, 3,  123, 3, 0, 1);
        add(0, 1, 0, 0,   12, 2, 0, 1);
        add(0, 1, 1, 10,  12, 2, 0, 1);
        add(0, 0, 1, 10,  12, 2, 1, 1);
        add(0, 1, 1, 0,   12, 2, 1, 1);
        add(0, 0, 1, 0,  120, 3, 0, 1);
        add(0, 1, 1, 0,  120, 3, 0, 1);
        add(0, 0, 0, 4,  120, 3, 1, 1);
        add(1, 1, 1, 0,  120, 3, 1, 0);
        add(1, 0, 1, 5,  120, 3, 1, 0);
        add(0, 1, 1, 0,    0, 0, 0, 1);
        foreach (vt[i]) begin
            step(vt[i].st, vt[i].k0, vt[i].k1, vt[i].d);
            check("vec value", value, vt[i].val);
            check("vec ndig", ndig, vt[i].nd);
            check("vec disp", disp, vt[i].val % 1000000);
            check("vec err", err, vt[i].e);
            check("vec active", active, vt[i].act);
        end

        commit(0); commit(0); commit(7);
        check("lead zero value", value, 7);
        check("lead zero ndig", ndig, 1);
        backsp();
        check("bs value", value, 0);
        backsp();
        check("bs empty ndig", ndig, 0);
        check("bs empty err", err, 0);

        repeat (12) commit(9);
        check("full value", value, 64'd999999999999);
        check("full ndig", ndig, 12);
        check("full disp", disp, 999999);
        commit(9);
        check("overfull value", value, 64'd999999999999);
        check("overfull err", err, 1);
        backsp();
        check("full bs value", value, 64'd99999999999);
        check("full bs ndig", ndig, 11);
        check("full bs err", err, 0);
        repeat (11) backsp();
        check("cleared ndig", ndig, 0);

        step(0, 1, 1, 5);
        repeat (50) step(0, 0, 1, 5);
        step(0, 1, 1, 5);
        check("hold value", value, 5);
        check("hold ndig", ndig, 1);

        step(0, 1, 1, 3);
        step(0, 0, 0, 3);
        check("both value", value, 5);
        check("both err", err, 1);
        step(0, 1, 1, 3);

        backsp(); commit(4); commit(2);
        check("42 value", value, 42);
        step(1, 1, 1, 0);
        check("leave value", value, 42);
        check("leave active", active, 0);
        step(1, 0, 1, 7);
        step(1, 1, 0, 7);
        check("idle value", value, 42);
        step(0, 1, 1, 0);
        check("reenter value", value, 0);
        check("reenter ndig", ndig, 0);
        check("reenter active", active, 1);

        commit(5); commit(5);
        step(0, 1, 1, 5);
        step(0, 0, 1, 5);
        check("555 value", value, 555);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset value", value, 0);
        check("midreset ndig", ndig, 0);
        check("midreset active", active, 0);
        stage = 2'd1;
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (4) step(0, 0, 1, 5);
        check("held after reset", value, 0);
        step(0, 1, 1, 5);
        step(0, 0, 1, 5);
        check("press after reset", value, 5);

        for (int i = 0; i < 800; i++) begin
            logic [1:0] st;
            logic [3:0] d;
            st = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            d  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
            step(st, 1'($urandom % 2), 1'($urandom_range(0, 5) != 0), d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
